// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async byte FIFO: pops head bytes and packs them
// little-endian into words, closing partial words on flush or idle timeout.
module fifo_rd_packer #(
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    fifo_empty,
  input  logic [7:0]              fifo_rdata,
  output logic                    fifo_rinc,
  input  logic                    flush,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]   out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL     = CW'(WORD_BYTES);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [8*WORD_BYTES-1:0] asm_data;
  logic [CW-1:0]           asm_cnt;
  logic [IW-1:0]           idle_cnt;
  logic                    flush_pend;

  logic                    full;
  logic                    timeout_hit;
  logic                    close;
  logic                    out_free;
  logic                    xfer;
  logic                    pop;
  logic [WORD_BYTES-1:0]   lane_keep;
  logic [8*WORD_BYTES-1:0] close_data;

  // Lanes at or above asm_cnt may hold bytes of an older word, so they are zeroed.
  always_comb begin
    lane_keep  = '0;
    close_data = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      lane_keep[k] = (CW'(k) < asm_cnt);
      if (lane_keep[k]) close_data[8*k +: 8] = asm_data[8*k +: 8];
    end
  end

  assign full        = (asm_cnt == FULL);
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_MAX);
  assign close       = full || ((asm_cnt != '0) && (flush_pend || timeout_hit));
  assign out_free    = !out_valid || out_ready;
  assign xfer        = close && out_free;
  assign pop         = rrst && !fifo_empty && !flush_pend && (!full || xfer);
  assign fifo_rinc   = pop;
  assign busy        = (asm_cnt != '0) || out_valid || flush_pend;

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      asm_data   <= '0;
      asm_cnt    <= '0;
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (xfer) begin
        out_data  <= close_data;
        out_keep  <= lane_keep;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A pop coinciding with a close starts the next word in lane 0.
      if (pop) begin
        if (xfer) begin
          asm_data[7:0] <= fifo_rdata;
          asm_cnt       <= CW'(1);
        end else begin
          for (int k = 0; k < WORD_BYTES; k++) begin
            if (asm_cnt == CW'(k)) asm_data[8*k +: 8] <= fifo_rdata;
          end
          asm_cnt <= asm_cnt + 1'b1;
        end
      end else if (xfer) begin
        asm_cnt <= '0;
      end

      if (pop || xfer) begin
        idle_cnt <= '0;
      end else if ((asm_cnt != '0) && fifo_empty && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      // Pops are blocked while pending, so an empty assembler means nothing left to flush.
      if (flush_pend) begin
        if (xfer || (asm_cnt == '0)) flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule
